// File: rtl/branch_redirect_ctrl.sv
// Control-flow resolution for the 5-stage core: static not-taken, redirect on taken
// branches, load-to-branch stall in ID, and saturating branch/taken performance counters.
module branch_redirect_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_id_valid,
    input  logic             i_id_is_branch,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_ex_valid,
    input  logic             i_ex_is_load,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_branch_en,
    input  logic             i_ex_taken,
    input  logic [XLEN-1:0]  i_ex_target,
    input  logic             i_fetch_ready,
    output logic             o_stall,
    output logic             o_flush_if,
    output logic             o_flush_id,
    output logic             o_flush_ex,
    output logic             o_redirect_valid,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_br_count,
    output logic [CNT_W-1:0] o_taken_count
);

    typedef enum logic {
        RUN      = 1'b0,
        REDIRECT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state_q;
    logic              flush_q;
    logic              redirect_valid_q;
    logic [XLEN-1:0]   redirect_pc_q;
    logic [CNT_W-1:0]  br_count_q;
    logic [CNT_W-1:0]  taken_count_q;

    logic res;
    logic take;
    logic haz;

    // EX/ID inputs are wrong-path while REDIRECT is active, so every event is gated by RUN.
    assign res  = (state_q == RUN) & i_ex_valid & i_ex_branch_en;
    assign take = res & i_ex_taken;
    assign haz  = (state_q == RUN) & i_id_valid & i_id_is_branch & i_ex_valid & i_ex_is_load
                & (i_ex_rd != 5'd0) & ((i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2));

    assign o_stall = haz & ~take;

    // Redirect handshake: o_redirect_valid rises with a stable o_redirect_pc and both are
    // held until a cycle where i_fetch_ready=1; the request drops at the following edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q          <= RUN;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            br_count_q       <= '0;
            taken_count_q    <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (take) begin
                        state_q          <= REDIRECT;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= i_ex_target;
                    end
                end
                REDIRECT: begin
                    if (i_fetch_ready) begin
                        state_q          <= RUN;
                        flush_q          <= 1'b0;
                        redirect_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q          <= RUN;
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                end
            endcase

            if (res && (br_count_q != CNT_MAX)) begin
                br_count_q <= br_count_q + 1'b1;
            end
            if (take && (taken_count_q != CNT_MAX)) begin
                taken_count_q <= taken_count_q + 1'b1;
            end
        end
    end

    assign o_flush_if       = flush_q;
    assign o_flush_id       = flush_q;
    assign o_flush_ex       = flush_q;
    assign o_redirect_valid = redirect_valid_q;
    assign o_redirect_pc    = redirect_pc_q;
    assign o_br_count       = br_count_q;
    assign o_taken_count    = taken_count_q;

endmodule
